// File: rtl/exu_mdu_pkg.sv
// Shared definitions for the exu_mdu multiply/divide unit: op codes, FSM
// state encoding, default width and small op-decode helpers.
package exu_mdu_pkg;

  // Base datapath width of the CPU; the MDU defaults to the same width.
  localparam int CPU_WIDTH = 64;
  localparam int MDU_XLEN  = CPU_WIDTH;

  localparam int MDU_OP_WIDTH = 3;

  typedef enum logic [MDU_OP_WIDTH-1:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Ops 4..7 are the divide family.
  function automatic logic op_is_div(input logic [MDU_OP_WIDTH-1:0] op);
    return op[2];
  endfunction

  // REM and REMU return the remainder.
  function automatic logic op_is_rem(input logic [MDU_OP_WIDTH-1:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_src1_signed(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM.
  function automatic logic op_src2_signed(input logic [MDU_OP_WIDTH-1:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_core_iter.sv
// Iterative datapath for exu_mdu: operand conditioning (absolute values and
// result sign), one shared adder used for shift-add multiply and restoring
// divide, the step counter, and the final sign fix-up of the result.
module mdu_core_iter
  import exu_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_step,
  input  logic [MDU_OP_WIDTH-1:0] i_op,
  input  logic [XLEN-1:0]         i_src1,
  input  logic [XLEN-1:0]         i_src2,
  output logic                    o_done,
  output logic [XLEN-1:0]         o_res
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(XLEN);

  // Accumulator: multiply {product_hi, multiplier}, divide {remainder, quotient}.
  logic [2*XLEN-1:0]       acc_q, acc_d;
  logic [XLEN-1:0]         dvs_q, dvs_d;   // multiplicand or divisor magnitude
  logic [MDU_OP_WIDTH-1:0] op_q, op_d;
  logic                    neg_q, neg_d;   // final result needs negation
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic            a_neg, b_neg, res_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  logic            is_div;
  logic [XLEN:0]   add_a, add_b;
  logic [XLEN+1:0] sum;
  logic [2*XLEN-1:0] step_acc;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign o_done = (cnt_q == CNT_END);

  // Split incoming operands into magnitude and sign according to the op.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    a_neg   = op_src1_signed(i_op) & i_src1[XLEN-1];
    b_neg   = op_src2_signed(i_op) & i_src2[XLEN-1];
    a_abs   = a_neg ? -i_src1 : i_src1;
    b_abs   = b_neg ? -i_src2 : i_src2;
    res_neg = op_is_rem(i_op) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration of the shared adder: add multiplicand or trial-subtract divisor.
  always_comb begin
    is_div = op_is_div(op_q);
    if (is_div) begin
      add_a = acc_q[2*XLEN-1:XLEN-1];      // remainder shifted left by one
      add_b = ~{1'b0, dvs_q};
    end else begin
      add_a = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_b = {1'b0, dvs_q};
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div};

    if (is_div) begin
      // Carry out set means the trial subtraction did not borrow.
      if (sum[XLEN+1]) step_acc = {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else             step_acc = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc_q[0]) step_acc = {sum[XLEN:0], acc_q[XLEN-1:1]};
      else          step_acc = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // Load on start, otherwise advance one step per enabled cycle until done.
  always_comb begin
    acc_d = acc_q;
    dvs_d = dvs_q;
    op_d  = op_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    if (i_start) begin
      acc_d = {{XLEN{1'b0}}, a_abs};
      dvs_d = b_abs;
      op_d  = i_op;
      neg_d = res_neg;
      cnt_d = '0;
    end else if (i_step && !o_done) begin
      acc_d = step_acc;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: non-blocking assignments so each flop captures pre-edge values.
    if (!i_rst_n) begin
      acc_q <= '0;
      dvs_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      dvs_q <= dvs_d;
      op_q  <= op_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
    end
  end

  // Apply the result sign and select the requested half/quantity.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MDU_MUL:                        o_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: o_res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              o_res = neg_q ? -quo : quo;
      default:                        o_res = neg_q ? -rem : rem;
    endcase
  end

endmodule

// File: rtl/exu_mdu.sv
// exu_mdu: multi-cycle RISC-V M-extension unit. Holds the IDLE/BUSY/DONE
// FSM, valid/ready handshakes, flush and the divide special cases; the
// iterative arithmetic lives in mdu_core_iter.
// Optional build macro EXU_MDU_FAST_MUL_EN: multiplies use a single-cycle
// combinational product instead of the iterative path.
module exu_mdu
  import exu_mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int TAG_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [MDU_OP_WIDTH-1:0] i_op,
  input  logic [XLEN-1:0]         i_src1,
  input  logic [XLEN-1:0]         i_src2,
  input  logic [TAG_W-1:0]        i_tag,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [XLEN-1:0]         o_res,
  output logic [TAG_W-1:0]        o_tag,
  output logic                    o_busy
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             spec_q, spec_d;   // result already known at accept

  logic            core_start, core_step, core_done;
  logic [XLEN-1:0] core_res;

  logic            div_zero, div_ovf, spec_hit;
  logic [XLEN-1:0] spec_res;

`ifdef EXU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
  logic [XLEN-1:0]   fast_res;

  // Full-width product of sign- or zero-extended operands.
  always_comb begin
    fm_a     = {{XLEN{op_src1_signed(i_op) & i_src1[XLEN-1]}}, i_src1};
    fm_b     = {{XLEN{op_src2_signed(i_op) & i_src2[XLEN-1]}}, i_src2};
    fm_p     = fm_a * fm_b;
    fast_res = (i_op == MDU_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
  end
`endif

  // Results that bypass iteration: divide by zero, signed overflow, fast multiply.
  always_comb begin
    div_zero = op_is_div(i_op) && (i_src2 == '0);
    div_ovf  = op_is_div(i_op) && op_src1_signed(i_op) &&
               (i_src1 == XMIN) && (i_src2 == '1);
    spec_hit = 1'b0;
    spec_res = '0;
    if (div_zero) begin
      spec_hit = 1'b1;
      spec_res = op_is_rem(i_op) ? i_src1 : '1;
    end else if (div_ovf) begin
      spec_hit = 1'b1;
      spec_res = op_is_rem(i_op) ? '0 : XMIN;
    end
`ifdef EXU_MDU_FAST_MUL_EN
    else if (!op_is_div(i_op)) begin
      spec_hit = 1'b1;
      spec_res = fast_res;
    end
`endif
  end

  // FSM next state, accept capture and result fix-up capture.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    res_d      = res_q;
    spec_d     = spec_q;
    core_start = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        // Flush has priority over a new request.
        if (i_valid && !i_flush) begin
          state_d    = MDU_BUSY;
          tag_d      = i_tag;
          core_start = 1'b1;
          spec_d     = spec_hit;
          if (spec_hit) res_d = spec_res;
        end
      end
      MDU_BUSY: begin
        if (i_flush) begin
          state_d = MDU_IDLE;
        end else if (spec_q) begin
          state_d = MDU_DONE;
        end else if (core_done) begin
          state_d = MDU_DONE;
          res_d   = core_res;
        end
      end
      MDU_DONE: begin
        if (i_flush || i_ready) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= MDU_IDLE;
      tag_q   <= '0;
      res_q   <= '0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      spec_q  <= spec_d;
    end
  end

  assign core_step = (state_q == MDU_BUSY) && !spec_q;

  mdu_core_iter #(
    .XLEN (XLEN)
  ) u_core (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (core_start),
    .i_step  (core_step),
    .i_op    (i_op),
    .i_src1  (i_src1),
    .i_src2  (i_src2),
    .o_done  (core_done),
    .o_res   (core_res)
  );

  assign o_ready = (state_q == MDU_IDLE);
  assign o_busy  = (state_q != MDU_IDLE);
  assign o_valid = (state_q == MDU_DONE);
  assign o_res   = res_q;
  assign o_tag   = tag_q;

endmodule

// File: doc/exu_mdu.md
Name: exu_mdu

Overview:
Multi-cycle RISC-V M-extension execute unit, width-parametrised successor to the single-cycle EXU arithmetic path.
- Sits beside the EXU in the execute stage and takes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Iterative shift-add multiplier and restoring divider share one datapath.
- Valid/ready handshakes on input and output; supports flush.

Parameters:
XLEN, 64, operand/result width (must be even, >=8)
TAG_W, 5, width of opaque tag (rd index) carried with the op

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_valid  in  1  op request
o_ready  out  1  unit can accept (state IDLE)
i_op  in  3  0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
i_src1  in  XLEN  rs1 value
i_src2  in  XLEN  rs2 value
i_tag  in  TAG_W  opaque tag
i_flush  in  1  abort in-flight op
o_valid  out  1  result available
i_ready  in  1  consumer accepts result
o_res  out  XLEN  result
o_tag  out  TAG_W  tag of result
o_busy  out  1  state != IDLE

Behaviour:
- Clock is i_clk; reset i_rst_n is asynchronous, active-low.
- Reset: state IDLE, o_valid=0, o_res=0, o_tag=0, o_busy=0, o_ready=1, counter=0.
- FSM: IDLE -> BUSY on i_valid&o_ready; BUSY -> DONE when counter reaches XLEN-1 step; DONE -> IDLE on i_ready.
- Accept: latch op, tag, absolute operands, result-sign flags. Signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU/MUL unsigned; DIV/REM signed, DIVU/REMU unsigned.
- Multiply: one partial-product bit per cycle, 2·XLEN accumulator. MUL returns low XLEN bits. MULH* return high XLEN bits after conditional two's-complement negation of the full 2·XLEN product.
- Divide: restoring, one quotient bit per cycle. Quotient sign = src1 sign XOR src2 sign; remainder sign = dividend sign.
- Latency: o_valid rises exactly XLEN+1 cycles after the accept edge (XLEN iterate + 1 fixup/negate).
- Special cases skip iteration; o_valid rises 1 cycle after accept:
  - divisor 0: DIV/DIVU quotient = all ones; REM/REMU = src1.
  - signed overflow (src1=MIN, src2=-1): DIV = MIN; REM = 0.
- Output hold: o_res/o_tag/o_valid stable while o_valid&~i_ready. o_ready=0 in BUSY and DONE, so there is no same-cycle accept-on-drain; the next accept is possible the cycle after the DONE->IDLE transition.
- i_flush:
  - in BUSY or DONE: next state IDLE, o_valid=0, result discarded.
  - in IDLE with i_valid: request is not accepted (flush wins).
- Reset mid-operation: immediate return to reset values; partial state lost.

Optional Feature:
Macro EXU_MDU_FAST_MUL_EN.
- Defined: multiply ops use a combinational 2·XLEN signed/unsigned product registered once; o_valid rises 1 cycle after accept (same timing as the special cases). Divides are unchanged.
- Undefined: iterative multiply with XLEN+1 latency as above; no wide multiplier is inferred.

Decomposition:
- Shared package/defines header holds:
  - MDU_OP_WIDTH=3 and the eight op codes.
  - FSM state encodings IDLE/BUSY/DONE (2 bits).
  - The XLEN default, reusing CPU_WIDTH.
- One natural sub-module, mdu_core_iter: operand conditioning plus shared shift-add/subtract datapath with step counter. The top keeps the FSM, handshakes and special-case detection.

Test Plan:
- MULHU, XLEN=64: src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 -> o_res=1, o_valid 65 cycles after accept, tag echoed.
- DIV: src1=-7, src2=2 -> DIV=-3 (0xFFFF_FFFF_FFFF_FFFD); REM: src1=-7, src2=2 -> REM=-1; REMU: src1=7, src2=3 -> 1.
- DIVU: src1=5, src2=0 -> all ones after 1 cycle. REM: src1=0x8000_0000_0000_0000, src2=-1 -> 0 after 1 cycle.
- Backpressure: i_ready=0 for 10 cycles after o_valid -> o_res/o_tag stable, o_ready=0, new i_valid ignored; i_ready=1 -> next op accepted the following cycle.
- Flush at BUSY cycle 20 of a MUL -> o_valid never rises; next op (MUL 3×4) -> 12.
- Assert i_rst_n low mid-DIV -> all outputs at reset values immediately; a fresh op after release completes correctly.
